// File: rtl/cla_adder_4bit_pkg.sv
// cla_adder_4bit_pkg: lookahead group size shared by the adder and its groups
package cla_adder_4bit_pkg;
  localparam int GRP = 4;
endpackage

// File: rtl/cla_adder_4bit_if.sv
// cla_adder_4bit_if: operand/result bundle between an ALU and the registered adder
interface cla_adder_4bit_if #(parameter int WIDTH = 4);
  logic in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic out_valid;
  logic [WIDTH-1:0] s;
  logic cout;
  logic pg;
  logic gg;
  modport master (output in_valid, a, b, cin, input out_valid, s, cout, pg, gg);
  modport slave (input in_valid, a, b, cin, output out_valid, s, cout, pg, gg);
endinterface

// File: rtl/cla_adder_4bit_group4.sv
// cla_group4: combinational 4-bit lookahead group producing sum and group propagate/generate
module cla_group4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c0,
  output logic [3:0] o_s,
  output logic       o_pg,
  output logic       o_gg
);
  logic [3:0] w_p, w_g, w_c;
  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;
  assign w_c[0] = i_c0;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c0);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c0);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) | (w_p[2] & w_p[1] & w_p[0] & i_c0);
  assign o_s = w_p ^ w_c;
  assign o_pg = &w_p;
  assign o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

// File: rtl/cla_adder_4bit.sv
// cla_adder_4bit: registered carry-lookahead adder, 4-bit groups under one second-level lookahead
module cla_adder_4bit
  import cla_adder_4bit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst,
  cla_adder_4bit_if.slave bus
);
  localparam int NG = WIDTH / GRP;
  if (WIDTH % GRP != 0 || WIDTH < GRP || WIDTH > 4 * GRP) begin : g_bad_width
    $error("cla_adder_4bit: WIDTH must be 4, 8, 12 or 16");
  end
  logic [NG-1:0] w_gpk, w_ggk, w_gc;
  logic [WIDTH-1:0] w_s;
  logic w_pg, w_gg, w_cout;
  logic r_valid, r_cout, r_pg, r_gg;
  logic [WIDTH-1:0] r_s;
  // flattened sum-of-products carry into group k; fixed loop bounds keep it unrollable
  function automatic logic carry_into(input logic [NG-1:0] p, input logic [NG-1:0] g, input logic c, input int k);
    logic r, t;
    r = 1'b0;
    for (int j = 0; j < NG; j++) begin
      t = g[j] & (j < k);
      for (int m = 0; m < NG; m++) t = t & ((m > j && m < k) ? p[m] : 1'b1);
      r = r | t;
    end
    t = c;
    for (int m = 0; m < NG; m++) t = t & ((m < k) ? p[m] : 1'b1);
    return r | t;
  endfunction
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .i_a (bus.a[GRP*k +: GRP]),
      .i_b (bus.b[GRP*k +: GRP]),
      .i_c0(w_gc[k]),
      .o_s (w_s[GRP*k +: GRP]),
      .o_pg(w_gpk[k]),
      .o_gg(w_ggk[k])
    );
  end
  always_comb begin
    w_gc = '0;
    for (int k = 0; k < NG; k++) w_gc[k] = carry_into(w_gpk, w_ggk, bus.cin, k);
    w_pg = &w_gpk;
    w_gg = carry_into(w_gpk, w_ggk, 1'b0, NG);
    w_cout = w_gg | (w_pg & bus.cin);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_s <= '0;
      r_cout <= 1'b0;
      r_pg <= 1'b0;
      r_gg <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s <= w_s;
        r_cout <= w_cout;
        r_pg <= w_pg;
        r_gg <= w_gg;
      end
    end
  end
  assign bus.out_valid = r_valid;
  assign bus.s = r_s;
  assign bus.cout = r_cout;
  assign bus.pg = r_pg;
  assign bus.gg = r_gg;
endmodule

// File: tb/tb_cla_adder_4bit.sv
// tb_cla_adder_4bit: directed and random checks of 4- and 16-bit builds against arithmetic models
module tb_cla_adder_4bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] e4 = '0;
  logic [19:0] e16 = '0;
  cla_adder_4bit_if #(.WIDTH(4)) b4 ();
  cla_adder_4bit_if #(.WIDTH(16)) b16 ();
  cla_adder_4bit #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  cla_adder_4bit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  always #5 clk = ~clk;
  // {cout, pg, gg, s}: gg is the carry out with no carry in, pg means a+b is all ones
  function automatic logic [6:0] m4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] t, u;
    u = {1'b0, a} + {1'b0, b};
    t = u + {4'b0, c};
    return {t[4], u == 5'd15, u[4], t[3:0]};
  endfunction
  function automatic logic [18:0] m16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] t, u;
    u = {1'b0, a} + {1'b0, b};
    t = u + {16'b0, c};
    return {t[16], u == 17'h0ffff, u[16], t[15:0]};
  endfunction
  task automatic step(input string tag, input logic r, input logic v4, input logic [3:0] a4, input logic [3:0] bb4,
                      input logic c4, input logic v16, input logic [15:0] a16, input logic [15:0] bb16, input logic c16);
    logic [7:0] o4;
    logic [19:0] o16;
    @(negedge clk);
    rst = r;
    b4.in_valid = v4; b4.a = a4; b4.b = bb4; b4.cin = c4;
    b16.in_valid = v16; b16.a = a16; b16.b = bb16; b16.cin = c16;
    e4 = r ? 8'd0 : {v4, v4 ? m4(a4, bb4, c4) : e4[6:0]};
    e16 = r ? 20'd0 : {v16, v16 ? m16(a16, bb16, c16) : e16[18:0]};
    @(posedge clk);
    #1;
    o4 = {b4.out_valid, b4.cout, b4.pg, b4.gg, b4.s};
    o16 = {b16.out_valid, b16.cout, b16.pg, b16.gg, b16.s};
    n_total++;
    assert (o4 === e4) n_pass++;
    else $error("FAIL %s w4 {valid,cout,pg,gg,s} got %b want %b", tag, o4, e4);
    n_total++;
    assert (o16 === e16) n_pass++;
    else $error("FAIL %s w16 {valid,cout,pg,gg,s} got %h want %h", tag, o16, e16);
  endtask
  initial begin
    b4.in_valid = 1'b0; b4.a = '0; b4.b = '0; b4.cin = 1'b0;
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0;
    step("reset", 1, 1, 4'b1111, 4'b1111, 1, 1, 16'hffff, 16'hffff, 1);
    step("reset2", 1, 1, 4'b1111, 4'b1111, 0, 1, 16'hffff, 16'h0001, 0);
    step("add1", 0, 1, 4'b0001, 4'b0000, 0, 1, 16'h0001, 16'h0000, 0);
    step("add7", 0, 1, 4'b0100, 4'b0011, 0, 1, 16'h0f00, 16'h00ff, 0);
    step("b2b_a", 0, 1, 4'b1101, 4'b1010, 1, 1, 16'hd000, 16'ha000, 1);
    step("b2b_b", 0, 1, 4'b1110, 4'b1001, 0, 1, 16'hfff0, 16'h0011, 0);
    step("b2b_c", 0, 1, 4'b1111, 4'b1010, 0, 1, 16'hffff, 16'hffff, 1);
    step("prop_c1", 0, 1, 4'b1010, 4'b0101, 1, 1, 16'haaaa, 16'h5555, 1);
    step("prop_c0", 0, 1, 4'b1010, 4'b0101, 0, 1, 16'haaaa, 16'h5555, 0);
    step("hold_a", 0, 0, 4'b0011, 4'b0110, 1, 0, 16'h1234, 16'h4321, 1);
    step("hold_b", 0, 0, 4'b1111, 4'b1111, 1, 0, 16'hffff, 16'hffff, 1);
    step("pre_rst", 0, 1, 4'b1000, 4'b1000, 0, 1, 16'h8000, 16'h8000, 0);
    step("mid_rst", 1, 1, 4'b0111, 4'b0001, 0, 1, 16'h7fff, 16'h0001, 0);
    step("idle", 0, 0, 4'b0111, 4'b0001, 0, 0, 16'h7fff, 16'h0001, 0);
    step("first", 0, 1, 4'b0111, 4'b0001, 0, 1, 16'h7fff, 16'h0001, 0);
    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      iv = i[8:0];
      step("sweep", 0, 1, iv[3:0], iv[7:4], iv[8], $urandom_range(0, 3) != 0,
           16'($urandom), 16'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 64; i++)
      step("rand", 0, $urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
